// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | seg7_pkg: glyph table and FSM states for the 7-seg capture.     |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package seg7_pkg;

  // Active-low pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high a..g (bit6=a ... bit0=g), indexed by nibble value.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// +----------------------------------------------------------------+
// | seg7_to_hex: active-high segment pattern to {hit, nibble}.      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_GLYPH[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// +----------------------------------------------------------------+
// | seg7_capture: recovers hex digits from a multiplexed 7-seg bus. |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [6:0]                  seg_n,
  input  logic [N_DIGITS-1:0]         an_n,
  output logic [4*N_DIGITS-1:0]       value,
  output logic [N_DIGITS-1:0]         digit_valid,
  output logic                        frame_valid,
  output logic                        err,
  output logic [$clog2(N_DIGITS)-1:0] err_digit
);

  localparam int                  IDX_W    = $clog2(N_DIGITS);
  localparam int                  SNAP_W   = 7 + N_DIGITS;
  localparam logic [7:0]          CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [6:0]            s_seg_q;
  logic [N_DIGITS-1:0]   s_an_q;
  logic [SNAP_W-1:0]     prev_q;
  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic [N_DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_pend_q, frame_pend_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      err_digit_q, err_digit_d;

  logic [N_DIGITS-1:0]   an_act;
  logic                  active;
  logic [IDX_W-1:0]      active_idx;
  logic                  changed;
  logic                  capture;
  logic                  glyph_hit;
  logic [3:0]            glyph_nib;

  assign an_act  = ~s_an_q;
  assign active  = (an_act != '0) && ((an_act & (an_act - AN_ONE)) == '0);
  assign changed = ({s_seg_q, s_an_q} != prev_q);

  always_comb begin
    active_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (an_act[i]) active_idx = IDX_W'(i);
    end
  end

  seg7_to_hex u_dec (
    .pattern (~s_seg_q),
    .hit     (glyph_hit),
    .nibble  (glyph_nib)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!active) begin
          state_d = IDLE;
        end else if (changed) begin
          cnt_d = 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (changed) begin
          state_d = active ? SETTLE : IDLE;
          cnt_d   = 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame clear happens first so a capture on the same edge survives it.
  always_comb begin
    value_d       = value_q;
    digit_valid_d = digit_valid_q;
    frame_valid_d = frame_pend_q;
    frame_pend_d  = 1'b0;
    err_d         = 1'b0;
    err_digit_d   = err_digit_q;
    if (frame_pend_q) digit_valid_d = '0;
    if (capture) begin
      if (glyph_hit) begin
        value_d[{active_idx, 2'b00} +: 4] = glyph_nib;
        digit_valid_d[active_idx]         = 1'b1;
        frame_pend_d = (active_idx == IDX_LAST) && (&digit_valid_d);
      end else begin
        err_d                     = 1'b1;
        err_digit_d               = active_idx;
        digit_valid_d[active_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg_q       <= SEG_BLANK;
      s_an_q        <= '1;
      prev_q        <= '1;
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      value_q       <= '0;
      digit_valid_q <= '0;
      frame_valid_q <= 1'b0;
      frame_pend_q  <= 1'b0;
      err_q         <= 1'b0;
      err_digit_q   <= '0;
    end else begin
      s_seg_q       <= seg_n;
      s_an_q        <= an_n;
      prev_q        <= {s_seg_q, s_an_q};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      digit_valid_q <= digit_valid_d;
      frame_valid_q <= frame_valid_d;
      frame_pend_q  <= frame_pend_d;
      err_q         <= err_d;
      err_digit_q   <= err_digit_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = digit_valid_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;
  assign err_digit   = err_digit_q;

endmodule
`default_nettype wire
